// File: rtl/aesl_deadlock_param_monitor_if.sv
// Bundle of signals between a dataflow region under co-simulation and its
// deadlock monitor.
//   master : drives clear, mask and the block/idle observations, reads the result
//   slave  : the monitor; reads the observations, drives the result
// Ports carried:
//   clear           sync clear of monitor state
//   axis_mask       per-channel enable for axis_block_sigs
//   axis_block_sigs 1 = stream channel blocked this cycle
//   inst_idle_sigs  1 = sub-instance idle
//   inst_block_sigs 1 = sub-instance blocked
//   block           confirmed deadlock
//   block_pending   blocked but not yet confirmed
//   stall_count     consecutive blocked cycles (saturating)
//   block_snapshot  OR of sources blocked since the episode began
//   first_src_idx   lowest source blocked when the episode began
interface aesl_deadlock_param_monitor_if #(
    parameter int N_AXIS = 3,
    parameter int N_INST = 1,
    parameter int CNT_W  = 16
);
    localparam int N_SRC = N_AXIS + N_INST;
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic                clear;
    logic [N_AXIS-1:0]   axis_mask;
    logic [N_AXIS-1:0]   axis_block_sigs;
    logic [N_INST-1:0]   inst_idle_sigs;
    logic [N_INST-1:0]   inst_block_sigs;
    logic                block;
    logic                block_pending;
    logic [CNT_W-1:0]    stall_count;
    logic [N_SRC-1:0]    block_snapshot;
    logic [IDX_W-1:0]    first_src_idx;

    modport master (
        output clear, axis_mask, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_pending, stall_count, block_snapshot, first_src_idx
    );

    modport slave (
        input  clear, axis_mask, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_pending, stall_count, block_snapshot, first_src_idx
    );
endinterface

// File: rtl/aesl_deadlock_param_monitor.sv
// Deadlock monitor for HLS dataflow regions. A blocked condition must persist
// for THRESHOLD consecutive cycles before it is reported, so transient
// backpressure is filtered out. The sources involved are captured for the
// report. With STICKY=1 the report holds until clear/reset.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-low
//   mon    slave side of aesl_deadlock_param_monitor_if
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | no blocked condition observed
// SUSPECT    | blocked, fewer than THRESHOLD consecutive cycles so far
// CONFIRMED  | blocked for THRESHOLD cycles; deadlock reported
module aesl_deadlock_param_monitor #(
    parameter int N_AXIS    = 3,
    parameter int N_INST    = 1,
    parameter int CNT_W     = 16,
    parameter int THRESHOLD = 1024,
    parameter int STICKY    = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    aesl_deadlock_param_monitor_if.slave   mon
);
    localparam int N_SRC = N_AXIS + N_INST;
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THR_LAST = CNT_W'(THRESHOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SUSPECT   = 2'd1,
        ST_CONFIRMED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_SRC-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_SRC-1:0]   src;
    logic               raw;
    logic [IDX_W-1:0]   low_idx;

    // All instances idle means the region has finished; blocks are then benign.
    always_comb begin
        src = {mon.inst_block_sigs, mon.axis_block_sigs & mon.axis_mask};
        raw = (|src) & ~(&mon.inst_idle_sigs);
    end

    // Descending scan so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        if (mon.clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            snap_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (raw) begin
                        state_d = (THRESHOLD == 1) ? ST_CONFIRMED : ST_SUSPECT;
                        cnt_d   = CNT_W'(1);
                        snap_d  = src;
                        idx_d   = low_idx;
                    end
                end
                ST_SUSPECT: begin
                    if (raw) begin
                        cnt_d  = cnt_q + 1'b1;
                        snap_d = snap_q | src;
                        if (cnt_q == THR_LAST) state_d = ST_CONFIRMED;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        snap_d  = '0;
                        idx_d   = '0;
                    end
                end
                ST_CONFIRMED: begin
                    if (raw) begin
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                        snap_d = snap_q | src;
                    end else if (STICKY == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        snap_d  = '0;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    snap_d  = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
        end
    end

    assign mon.block          = (state_q == ST_CONFIRMED);
    assign mon.block_pending  = (state_q == ST_SUSPECT);
    assign mon.stall_count    = cnt_q;
    assign mon.block_snapshot = snap_q;
    assign mon.first_src_idx  = idx_q;
endmodule
